pipe_drain_fifo: RTL and testbench
==================================

PIPE_DRAIN_FIFO -- requirements
Module: pipe_drain_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data width, identical to the WIDTH of the delay line it drains.
REQ-002 Parameter LATENCY, default 5: number of enable-gated stages in the upstream delay line; legal values 1..64.
REQ-003 Parameter DEPTH, default 4: output FIFO entries; a power of two, at least 2.
REQ-004 i_clk  in  1: single clock for the whole block.
REQ-005 i_reset  in  1: reset, synchronous, active-high; the same net also resets the delay line.
REQ-006 i_in_valid  in  1: upstream item is presented to the delay line input this cycle.
REQ-007 o_in_ready  out  1: upstream item is accepted this cycle; equal to o_pipe_enable.
REQ-008 o_pipe_enable  out  1: drives i_enable of the delay line.
REQ-009 i_pipe_data  in  WIDTH: last-stage data of the delay line.
REQ-010 i_pipe_valid  in  1: last-stage valid bit, carried through a 1-bit delay line of equal LATENCY.
REQ-011 o_out_data  out  WIDTH: FIFO head, show-ahead.
REQ-012 o_out_valid  out  1: FIFO non-empty.
REQ-013 i_out_ready  in  1: downstream consumer accepts the head.
REQ-014 o_inflight  out  clog2(LATENCY+1): number of valid items currently inside the delay line.
REQ-015 o_idle  out  1: high when o_inflight == 0 and the FIFO is empty.
REQ-016 o_err  out  1: sticky latency-mismatch flag.

Function
REQ-017 o_pipe_enable SHALL be 1 iff FIFO count < DEPTH; it is a function of registered state only, with no combinational path from i_out_ready.
REQ-018 Push: when o_pipe_enable && i_pipe_valid, i_pipe_data SHALL be written at the tail on that clock edge.
REQ-019 Pop: when o_out_valid && i_out_ready, the head SHALL advance; i_out_ready while empty SHALL be ignored.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-021 When full, the enable SHALL drop for that cycle even if a pop occurs; this one-cycle throughput loss is accepted.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH, with width clog2(DEPTH+1).
REQ-023 Inflight SHALL increment on (i_in_valid && o_pipe_enable) and decrement on (i_pipe_valid && o_pipe_enable); when both occur it SHALL stay unchanged.
REQ-024 End-to-end latency SHALL be LATENCY enabled cycles plus 1 cycle to reach o_out_valid with no stalls, i.e. 6 cycles at defaults.
REQ-025 o_err SHALL set on a decrement with inflight == 0, or an increment with inflight == LATENCY; it SHALL clear only on reset, and the counter SHALL saturate.
REQ-026 Data SHALL never be dropped or duplicated under any i_out_ready pattern.

Reset
REQ-027 On i_reset, at the next edge: count, pointers, inflight and o_err SHALL be 0; o_out_valid = 0, o_pipe_enable = 1, o_idle = 1, o_out_data = 0.
REQ-028 Reset mid-operation SHALL discard all buffered and in-flight items; nothing SHALL emerge after reset deasserts.

Structure
REQ-029 The clog2 constant function SHALL live in the shared package; no typedefs are required.
REQ-030 FIFO storage SHALL be one sub-module, drain_fifo_ram: DEPTH x WIDTH, one write port, async read, no reset on storage.
REQ-031 Control logic (count, pointers, inflight, err) SHALL remain in pipe_drain_fifo.

Verification
REQ-032 Streaming: i_in_valid=1 with data 1..20, i_out_ready=1 -> o_out_data 1..20 in order, first output 6 cycles after first input, o_in_ready always 1.
REQ-033 Backpressure: i_out_ready=0, 10 items sent -> o_pipe_enable falls after 4 pushes, o_inflight=5, nothing lost; then i_out_ready=1 -> all 10 out in order.
REQ-034 Random: random i_in_valid and i_out_ready for 1000 items -> scoreboard matches, o_err stays 0, o_idle=1 at end.
REQ-035 Reset: assert reset with FIFO=3 and inflight=4 -> next cycle o_out_valid=0, o_inflight=0, o_idle=1; no stale outputs during 10 following cycles.
REQ-036 Mismatch: force i_pipe_valid=1 with inflight=0 -> o_err=1 and stays set until reset.
REQ-037 Full plus pop: FIFO full, i_out_ready=1 for one cycle -> enable 0 that cycle, 1 the next, count 4->3.

Source files
------------

// File: rtl/pipe_drain_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_drain_fifo_pkg
//  Description : Shared helpers for the pipe drain FIFO slice. Provides the
//                ceiling-log2 constant function used to size counters and
//                pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_drain_fifo_pkg;

    // Smallest n such that 2**n >= value; used for parameter-derived widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : pipe_drain_fifo_pkg
`default_nettype wire

// File: rtl/drain_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : drain_fifo_ram
//  Description : DEPTH x WIDTH storage for the drain FIFO. One synchronous
//                write port, asynchronous (show-ahead) read port. Storage is
//                intentionally not reset; validity is tracked by the control.
//  Revision    : 1.0 - initial release
// ============================================================================
module drain_fifo_ram
    import pipe_drain_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_wr_en,
    input  logic [clog2(DEPTH)-1:0]   i_wr_addr,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic [clog2(DEPTH)-1:0]   i_rd_addr,
    output logic [WIDTH-1:0]          o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the tail entry when the control accepts an item from the pipe.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : drain_fifo_ram
`default_nettype wire

// File: rtl/pipe_drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_drain_fifo
//  Description : Drains an enable-gated delay line into a small show-ahead
//                FIFO. The delay-line enable is derived from the registered
//                FIFO count only, so a full FIFO freezes the whole pipe and
//                nothing in flight is lost. Tracks in-flight items and flags
//                any disagreement between that count and the pipe valid bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_drain_fifo
    import pipe_drain_fifo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 5,
    parameter int DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    output logic                          o_pipe_enable,
    input  logic [WIDTH-1:0]              i_pipe_data,
    input  logic                          i_pipe_valid,
    output logic [WIDTH-1:0]              o_out_data,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [clog2(LATENCY+1)-1:0]   o_inflight,
    output logic                          o_idle,
    output logic                          o_err
);

    localparam int c_cnt_w = clog2(DEPTH + 1);
    localparam int c_ptr_w = clog2(DEPTH);
    localparam int c_inf_w = clog2(LATENCY + 1);

    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_inf_w-1:0] c_lat   = c_inf_w'(LATENCY);

    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_inf_w-1:0] r_inflight;
    logic               r_err;

    logic               w_enable;
    logic               w_not_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_inc;
    logic               w_dec;
    logic [WIDTH-1:0]   w_rd_data;

    // Enable depends on registered count only: a full FIFO stalls the pipe
    // for one cycle even if the head is popped in that same cycle.
    assign w_enable    = (r_count < c_depth);
    assign w_not_empty = (r_count != '0);
    assign w_push      = w_enable & i_pipe_valid;
    assign w_pop       = w_not_empty & i_out_ready;
    assign w_inc       = w_enable & i_in_valid;
    assign w_dec       = w_enable & i_pipe_valid;

    drain_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_pipe_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // FIFO occupancy and pointers; pointers wrap naturally at DEPTH (2**n).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // In-flight tracking with saturation; any net move past either bound
    // means the pipe valid bit disagrees with what was sent, so flag it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_inc && !w_dec) begin
                if (r_inflight == c_lat) begin
                    r_err <= 1'b1;
                end else begin
                    r_inflight <= r_inflight + 1'b1;
                end
            end else if (w_dec && !w_inc) begin
                if (r_inflight == '0) begin
                    r_err <= 1'b1;
                end else begin
                    r_inflight <= r_inflight - 1'b1;
                end
            end
        end
    end

    assign o_pipe_enable = w_enable;
    assign o_in_ready    = w_enable;
    assign o_out_valid   = w_not_empty;
    assign o_out_data    = w_not_empty ? w_rd_data : '0;
    assign o_inflight    = r_inflight;
    assign o_idle        = (r_inflight == '0) && !w_not_empty;
    assign o_err         = r_err;

endmodule : pipe_drain_fifo
`default_nettype wire

// File: tb/tb_pipe_drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_drain_fifo
//  Description : Self-checking bench for pipe_drain_fifo. Contains a model of
//                the upstream enable-gated delay line and a queue-based
//                reference of items in flight and items buffered.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_drain_fifo;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 5;
    localparam int DEPTH   = 4;
    localparam int INF_W   = $clog2(LATENCY + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              out_ready;
    logic              force_pv;

    logic              in_ready;
    logic              pipe_en;
    logic [WIDTH-1:0]  pipe_data;
    logic              pipe_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic [INF_W-1:0]  inflight;
    logic              idle;
    logic              err;

    logic [WIDTH-1:0]  dl_data  [LATENCY];
    logic              dl_valid [LATENCY];

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] in_q[$];
    logic [WIDTH-1:0] f_q[$];
    int pushes;
    int pops;
    bit s_en;
    bit s_valid;
    bit s_pop;
    bit s_acc;
    int s_inflight;

    always #5 clk = ~clk;

    // Upstream delay line: LATENCY enable-gated stages for data and valid.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl_data[i]  <= '0;
                dl_valid[i] <= 1'b0;
            end
        end else if (pipe_en) begin
            dl_data[0]  <= in_data;
            dl_valid[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                dl_data[i]  <= dl_data[i-1];
                dl_valid[i] <= dl_valid[i-1];
            end
        end
    end

    assign pipe_data  = dl_data[LATENCY-1];
    assign pipe_valid = dl_valid[LATENCY-1] | force_pv;

    pipe_drain_fifo #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .o_pipe_enable (pipe_en),
        .i_pipe_data   (pipe_data),
        .i_pipe_valid  (pipe_valid),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_inflight    (inflight),
        .o_idle        (idle),
        .o_err         (err)
    );

    // One clock of the reference: inputs are already set at the negedge.
    // Compares DUT outputs to the queue model, then advances the model.
    task automatic model_cycle();
        bit exp_valid;
        bit exp_en;
        bit push;
        logic [WIDTH-1:0] d;
        #1;
        exp_valid = (f_q.size() != 0);
        exp_en    = (f_q.size() < DEPTH);
        n_checks++;
        if (out_valid !== exp_valid) $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_valid, $time);
        else n_pass++;
        n_checks++;
        if (pipe_en !== exp_en) $display("FAIL pipe_enable: got %b expected %b at %0t", pipe_en, exp_en, $time);
        else n_pass++;
        n_checks++;
        if (in_ready !== exp_en) $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_en, $time);
        else n_pass++;
        n_checks++;
        if (int'(inflight) != in_q.size() || $isunknown(inflight)) $display("FAIL inflight: got %0d expected %0d at %0t", inflight, in_q.size(), $time);
        else n_pass++;
        n_checks++;
        if (idle !== (in_q.size() == 0 && f_q.size() == 0)) $display("FAIL idle: got %b expected %b at %0t", idle, (in_q.size() == 0 && f_q.size() == 0), $time);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL err: got %b expected 0 at %0t", err, $time);
        else n_pass++;
        if (exp_valid) begin
            n_checks++;
            if (out_data !== f_q[0]) $display("FAIL out_data: got %0h expected %0h at %0t", out_data, f_q[0], $time);
            else n_pass++;
        end
        s_en       = exp_en;
        s_valid    = exp_valid;
        s_acc      = in_valid && exp_en;
        s_pop      = exp_valid && out_ready;
        s_inflight = int'(inflight);
        push       = pipe_valid && exp_en;
        if (s_pop) begin
            d = f_q.pop_front();
            pops++;
        end
        if (push) begin
            n_checks++;
            if (in_q.size() == 0) begin
                $display("FAIL spurious_push: got push expected none at %0t", $time);
            end else begin
                n_pass++;
                d = in_q.pop_front();
                f_q.push_back(d);
            end
            pushes++;
        end
        if (s_acc) in_q.push_back(in_data);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        force_pv  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        in_q.delete();
        f_q.delete();
        pushes = 0;
        pops   = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; force_pv = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (pipe_en !== 1'b1) $display("FAIL rst_pipe_enable: got %b expected 1", pipe_en); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b expected 1", idle); else n_pass++;
        n_checks++; if (inflight !== '0) $display("FAIL rst_inflight: got %0d expected 0", inflight); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b expected 0", err); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL rst_out_data: got %0h expected 0", out_data); else n_pass++;
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_streaming();
        int first_out;
        bit ready_ok;
        first_out = -1;
        ready_ok  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid = (i < 20);
            in_data  = (i < 20) ? WIDTH'(i + 1) : '0;
            model_cycle();
            if (i < 20 && !s_en) ready_ok = 1'b0;
            if (first_out < 0 && s_valid) first_out = i;
        end
        n_checks++; if (first_out != 6) $display("FAIL stream_latency: got %0d expected 6", first_out); else n_pass++;
        n_checks++; if (!ready_ok) $display("FAIL stream_in_ready: got stall expected always 1"); else n_pass++;
        n_checks++; if (pops != 20) $display("FAIL stream_count: got %0d expected 20", pops); else n_pass++;
    endtask

    task automatic test_backpressure();
        int sent;
        bit seen;
        sent = 0; seen = 1'b0; pushes = 0; pops = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (sent < 10);
            in_data  = WIDTH'(32'h100 + sent);
            model_cycle();
            if (s_acc) sent++;
            if (!s_en && !seen) begin
                seen = 1'b1;
                n_checks++; if (pushes != 4) $display("FAIL bp_pushes: got %0d expected 4", pushes); else n_pass++;
                n_checks++; if (s_inflight != 5) $display("FAIL bp_inflight: got %0d expected 5", s_inflight); else n_pass++;
            end
        end
        n_checks++; if (!seen) $display("FAIL bp_enable_drop: got never expected drop"); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (sent < 10 || in_q.size() != 0 || f_q.size() != 0); i++) begin
            in_valid = (sent < 10);
            in_data  = WIDTH'(32'h100 + sent);
            model_cycle();
            if (s_acc) sent++;
        end
        in_valid = 1'b0;
        n_checks++; if (pops != 10) $display("FAIL bp_drain: got %0d expected 10", pops); else n_pass++;
    endtask

    task automatic test_full_pop();
        int sent;
        sent = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 30 && f_q.size() < DEPTH; i++) begin
            in_valid = (sent < DEPTH);
            in_data  = WIDTH'(32'h200 + sent);
            model_cycle();
            if (s_acc) sent++;
        end
        in_valid = 1'b0;
        n_checks++; if (f_q.size() != DEPTH) $display("FAIL full_fill: got %0d expected %0d", f_q.size(), DEPTH); else n_pass++;
        out_ready = 1'b1;
        model_cycle();
        n_checks++; if (s_en || !s_pop) $display("FAIL full_pop_cycle: got en=%b pop=%b expected en=0 pop=1", s_en, s_pop); else n_pass++;
        out_ready = 1'b0;
        model_cycle();
        n_checks++; if (!s_en || f_q.size() != 3) $display("FAIL full_after_pop: got en=%b cnt=%0d expected en=1 cnt=3", s_en, f_q.size()); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) model_cycle();
    endtask

    task automatic test_random();
        int sent;
        int cyc;
        sent = 0; cyc = 0; pops = 0;
        while (sent < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < 60);
            model_cycle();
            if (s_acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (in_q.size() != 0 || f_q.size() != 0); i++) model_cycle();
        #1;
        n_checks++; if (pops != 1000) $display("FAIL rand_count: got %0d expected 1000", pops); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rand_err: got %b expected 0", err); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rand_idle: got %b expected 1", idle); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int sent;
        sent = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 30 && f_q.size() < 3; i++) begin
            in_valid = (sent < 7);
            in_data  = WIDTH'(32'h300 + sent);
            model_cycle();
            if (s_acc) sent++;
        end
        in_valid = 1'b0;
        #1;
        n_checks++; if (inflight !== INF_W'(4) || f_q.size() != 3) $display("FAIL mid_setup: got inflight=%0d fifo=%0d expected 4 and 3", inflight, f_q.size()); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (inflight !== '0) $display("FAIL mid_inflight: got %0d expected 0", inflight); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL mid_idle: got %b expected 1", idle); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        in_q.delete(); f_q.delete(); pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) model_cycle();
        n_checks++; if (pops != 0) $display("FAIL mid_stale: got %0d items expected 0", pops); else n_pass++;
    endtask

    task automatic test_mismatch();
        force_pv = 1'b1;
        @(negedge clk);
        force_pv = 1'b0;
        #1;
        n_checks++; if (err !== 1'b1) $display("FAIL mis_set: got %b expected 1", err); else n_pass++;
        repeat (5) @(negedge clk);
        #1;
        n_checks++; if (err !== 1'b1) $display("FAIL mis_sticky: got %b expected 1", err); else n_pass++;
        @(negedge clk);
        do_reset();
        #1;
        n_checks++; if (err !== 1'b0) $display("FAIL mis_clear: got %b expected 0", err); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mis_out_valid: got %b expected 0", out_valid); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        pushes = 0;
        pops   = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_pop();
        test_random();
        test_reset_mid();
        test_mismatch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_drain_fifo
`default_nettype wire
